fmap_pingpong_buf_1w5r: RTL and testbench

Double-buffered feature-map store between two CNN layer stages.
- Producer side: a layer's single-word write stream (addr/data/en, one word per cycle) plus an end-of-map pulse.
- Consumer side: the next layer's five-lane parallel read port (5 addresses in, 5 words out).
- Two banks alternate, so the producer fills one map while the consumer reads the other.
- A two-flag bank handshake tells each side when its bank is usable.

---
 rtl/fmap_pingpong_buf_1w5r.sv | 77 +++++++
 tb/tb_fmap_pingpong_buf_1w5r.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fmap_pingpong_buf_1w5r.sv
// fmap_pingpong_buf_1w5r: two-bank ping-pong feature-map store, one write port and LANES registered read ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data      : producer word stream into the current write bank
//   wr_done                    : producer commits the write bank
//   wr_ready                   : write bank is empty and may be filled
//   rd_addr_5P / rd_data_5P    : LANES packed read addresses in, packed data out one cycle later
//   rd_done                    : consumer releases the read bank
//   rd_valid                   : read bank holds a complete map
//   wr_err                     : sticky protocol/range error
//   wr_sel_o / rd_sel_o        : current bank indices
module fmap_pingpong_buf_1w5r #(
  parameter int DEPTH  = 400,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int LANES  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_done,
  output logic                      wr_ready,
  input  logic [LANES*ADDR_W-1:0]   rd_addr_5P,
  output logic [LANES*DATA_W-1:0]   rd_data_5P,
  input  logic                      rd_done,
  output logic                      rd_valid,
  output logic                      wr_err,
  output logic                      wr_sel_o,
  output logic                      rd_sel_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [1:0] full_q, full_d;
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, wr_err_q, wr_err_d;
  logic [LANES*DATA_W-1:0] rd_data_q, rd_data_d;
  logic wr_ok, commit, rel;
  assign wr_ready = !full_q[wr_sel_q];
  assign rd_valid = full_q[rd_sel_q];
  assign wr_ok = wr_en && wr_ready && wr_addr < LIM;
  assign commit = wr_done && wr_ready;
  assign rel = rd_done && rd_valid;
  // commit and release always hit different banks, so per-bit updates never collide
  always_comb begin
    full_d = full_q;
    if (commit) full_d[wr_sel_q] = 1'b1;
    if (rel) full_d[rd_sel_q] = 1'b0;
    wr_sel_d = wr_sel_q ^ commit;
    rd_sel_d = rd_sel_q ^ rel;
    wr_err_d = wr_err_q | (wr_en && !wr_ok) | (wr_done && !wr_ready);
    rd_data_d = '0;
    for (int i = 0; i < LANES; i++)
      if (rd_valid && rd_addr_5P[i*ADDR_W +: ADDR_W] < LIM)
        rd_data_d[i*DATA_W +: DATA_W] = mem[rd_sel_q][rd_addr_5P[i*ADDR_W +: AW]];
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_sel_q][wr_addr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full_q <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      full_q <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_err_q <= wr_err_d;
      rd_data_q <= rd_data_d;
    end
  assign rd_data_5P = rd_data_q;
  assign wr_err = wr_err_q;
  assign wr_sel_o = wr_sel_q;
  assign rd_sel_o = rd_sel_q;
endmodule

// File: tb/tb_fmap_pingpong_buf_1w5r.sv
// tb_fmap_pingpong_buf_1w5r: vector table, directed corner sequences and random traffic against a map-queue model
module tb_fmap_pingpong_buf_1w5r;
  localparam int DEPTH = 400;
  localparam int L = 5;
  logic clk = 0, rst_n = 0, wr_en = 0, wr_done = 0, rd_done = 0;
  logic [31:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic [L*32-1:0] rd_addr = 0;
  logic [L*16-1:0] rd_data;
  logic wr_ready, rd_valid, wr_err, wr_sel_o, rd_sel_o;
  int tests = 0, fails = 0;
  fmap_pingpong_buf_1w5r dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wr_ready), .rd_addr_5P(rd_addr), .rd_data_5P(rd_data),
    .rd_done(rd_done), .rd_valid(rd_valid), .wr_err(wr_err), .wr_sel_o(wr_sel_o), .rd_sel_o(rd_sel_o)
  );
  always #5 clk = ~clk;
  // model: maps are committed and released in order, so two counters describe the bank state
  int mc, mr;
  bit merr;
  logic [15:0] mm [2][DEPTH];
  bit kn [2][DEPTH];
  typedef struct {
    logic we; logic [31:0] wa; logic [15:0] wd; logic wdone; logic rdone;
    logic [L*32-1:0] ra; logic [4:0] flags; logic [L*16-1:0] rdat;
  } vec_t;
  vec_t tbl [10];
  function automatic logic [L*32-1:0] p5(int a0, int a1, int a2, int a3, int a4);
    return {32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction
  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic idle();
    wr_en = 0; wr_done = 0; rd_done = 0; rd_addr = 0;
  endtask
  task automatic tick();
    int n;
    bit rdy, vld;
    int a;
    logic [15:0] ed [L];
    bit care [L];
    n = mc - mr; rdy = n < 2; vld = n > 0;
    for (int i = 0; i < L; i++) begin
      a = int'(rd_addr[i*32 +: 32]);
      if (vld && rd_addr[i*32 +: 32] < DEPTH) begin
        ed[i] = mm[mr % 2][a]; care[i] = kn[mr % 2][a];
      end else begin
        ed[i] = 0; care[i] = 1;
      end
    end
    if (wr_en) begin
      if (rdy && wr_addr < DEPTH) begin
        mm[mc % 2][int'(wr_addr)] = wr_data; kn[mc % 2][int'(wr_addr)] = 1;
      end else merr = 1;
    end
    if (wr_done) begin
      if (rdy) mc++; else merr = 1;
    end
    if (rd_done && vld) mr++;
    @(posedge clk); #1;
    n = mc - mr;
    chk("flags", {wr_ready, rd_valid, wr_err, wr_sel_o, rd_sel_o}, {n < 2, n > 0, merr, mc[0], mr[0]});
    for (int i = 0; i < L; i++)
      if (care[i]) chk($sformatf("lane%0d", i), rd_data[i*16 +: 16], ed[i]);
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_flags", {wr_ready, rd_valid, wr_err, wr_sel_o, rd_sel_o}, 5'b10000);
    chk("rst_data", rd_data, 0);
    mc = 0; mr = 0; merr = 0;
    idle();
    @(posedge clk); #1 rst_n = 1;
  endtask
  initial begin
    // flags = {wr_ready, rd_valid, wr_err, wr_sel, rd_sel}; rdat = lane4..lane0
    tbl[0] = '{1, 32'd3, 16'hAAAA, 0, 0, p5(0,0,0,0,0), 5'b10000, 80'h0};
    tbl[1] = '{1, 32'd7, 16'h1234, 1, 0, p5(0,0,0,0,0), 5'b11010, 80'h0};
    tbl[2] = '{1, 32'd3, 16'h5555, 0, 0, p5(3,7,400,3,1000), 5'b11010, {16'h0, 16'hAAAA, 16'h0, 16'h1234, 16'hAAAA}};
    tbl[3] = '{0, 32'd0, 16'h0, 1, 0, p5(7,7,7,7,7), 5'b01000, {5{16'h1234}}};
    tbl[4] = '{1, 32'd3, 16'hFFFF, 0, 0, p5(3,3,3,3,3), 5'b01100, {5{16'hAAAA}}};
    tbl[5] = '{0, 32'd0, 16'h0, 0, 1, p5(3,3,3,3,3), 5'b11101, {5{16'hAAAA}}};
    tbl[6] = '{0, 32'd0, 16'h0, 0, 0, p5(3,3,3,3,3), 5'b11101, {5{16'h5555}}};
    tbl[7] = '{1, 32'd400, 16'h1, 0, 0, p5(3,3,3,3,500), 5'b11101, {16'h0, {4{16'h5555}}}};
    tbl[8] = '{0, 32'd0, 16'h0, 0, 1, p5(3,3,3,3,3), 5'b10100, {5{16'h5555}}};
    tbl[9] = '{0, 32'd0, 16'h0, 0, 1, p5(3,3,3,3,3), 5'b10100, 80'h0};
    mc = 0; mr = 0; merr = 0;
    #1;
    chk("init_flags", {wr_ready, rd_valid, wr_err, wr_sel_o, rd_sel_o}, 5'b10000);
    chk("init_data", rd_data, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      wr_done = tbl[i].wdone; rd_done = tbl[i].rdone; rd_addr = tbl[i].ra;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_flags", i), {wr_ready, rd_valid, wr_err, wr_sel_o, rd_sel_o}, tbl[i].flags);
      chk($sformatf("vec%0d_data", i), rd_data, tbl[i].rdat);
    end
    idle();
    do_reset();
    // fill bank0 with data=addr, commit, read
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1; wr_addr = a; wr_data = 16'(a); tick();
    end
    wr_en = 0; wr_done = 1; tick(); wr_done = 0;
    chk("commit0", {rd_valid, wr_sel_o, wr_ready}, 3'b111);
    rd_addr = p5(0, 1, 2, 3, 399); tick();
    chk("read0", rd_data, {16'd399, 16'd3, 16'd2, 16'd1, 16'd0});
    // partially fill bank1, then commit and release in the same cycle
    for (int a = 0; a < 10; a++) begin
      wr_en = 1; wr_addr = a; wr_data = 16'h100 + 16'(a); tick();
    end
    wr_en = 0; wr_done = 1; rd_done = 1; tick(); wr_done = 0; rd_done = 0;
    chk("swap", {rd_sel_o, wr_sel_o, rd_valid, wr_ready}, 4'b1011);
    // fill bank0 again so both banks are full
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1; wr_addr = a; wr_data = 16'(a) ^ 16'h5A5A; tick();
    end
    wr_en = 0; wr_done = 1; tick(); wr_done = 0;
    chk("both_full", wr_ready, 0);
    wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; tick(); wr_en = 0;
    chk("drop_err", wr_err, 1);
    rd_addr = p5(5, 5, 5, 5, 5); tick();
    chk("drop_unchanged", rd_data[15:0], 16'h0105);
    wr_done = 1; tick(); wr_done = 0;
    chk("done_not_ready", {wr_err, wr_sel_o}, 2'b11);
    rd_addr = p5(400, 1000, 0, 0, 2); tick();
    chk("pad_dup", rd_data, {16'h0102, 16'h0100, 16'h0100, 16'h0, 16'h0});
    // release bank1, start refilling it, reset mid-fill
    rd_addr = 0; rd_done = 1; tick(); rd_done = 0;
    for (int a = 0; a < 5; a++) begin
      wr_en = 1; wr_addr = a; wr_data = 16'hC000 + 16'(a); tick();
    end
    do_reset();
    rd_done = 1; tick(); tick(); rd_done = 0;
    chk("rd_done_idle", {wr_err, rd_sel_o, rd_valid}, 3'b000);
    rd_addr = p5(0, 1, 2, 3, 4); tick();
    chk("read_invalid", rd_data, 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      wr_en = $urandom_range(0, 3) != 0;
      wr_addr = ($urandom_range(0, 15) == 0) ? $urandom_range(400, 2000) : $urandom_range(0, 399);
      wr_data = 16'($urandom);
      wr_done = $urandom_range(0, 40) == 0;
      rd_done = $urandom_range(0, 30) == 0;
      for (int i = 0; i < L; i++)
        rd_addr[i*32 +: 32] = ($urandom_range(0, 20) == 0) ? $urandom : $urandom_range(0, 420);
      if ($urandom_range(0, 499) == 0) do_reset(); else tick();
    end
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
